// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package seg_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EDIT = 1'b1
  } state_e;

  localparam int              BCD_W     = 4;
  localparam logic [BCD_W-1:0] BCD_MAX  = 4'd9;
  localparam logic [7:0]      ANODE_OFF = 8'hFF;

  // Anything at or above 9 (including loaded non-BCD codes) rolls to 0.
  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] d);
    return (d >= BCD_MAX) ? '0 : d + 1'b1;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: counts 0..DIV-1 and flags the last count as a one-cycle tick.
module tick_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_tick
);

  localparam int               CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_cnt <= '0;
    else if (r_cnt == LAST) r_cnt <= '0;
    else                   r_cnt <= r_cnt + 1'b1;
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/seg_scan_ctrl.sv
// N-digit BCD display controller: digit registers, edit FSM, and the scan/blink
// drive for one shared BCD-to-segment decoder.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load,
  input  logic [BCD_W*NUM_DIGITS-1:0] load_bcd,
  input  logic                        btn_mode,
  input  logic                        btn_next,
  input  logic                        btn_inc,
  output logic [BCD_W*NUM_DIGITS-1:0] digits_out,
  output logic                        editing,
  output logic [BCD_W-1:0]            bcd_out,
  output logic                        blink_out,
  output logic                        blink_phase,
  output logic [NUM_DIGITS-1:0]       an_n
);

  localparam int               SEL_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [SEL_W-1:0] LAST_DIG = SEL_W'(NUM_DIGITS - 1);

  state_e                      r_state, w_state_nxt;
  logic [SEL_W-1:0]            r_sel;
  logic [SEL_W-1:0]            r_scan_idx;
  logic [BCD_W*NUM_DIGITS-1:0] r_digits;
  logic [BCD_W-1:0]            r_bcd;
  logic [NUM_DIGITS-1:0]       r_an_n;
  logic [NUM_DIGITS-1:0]       w_an_nxt;
  logic                        r_blink;
  logic                        r_phase;
  logic                        w_scan_tick;
  logic                        w_blink_tick;
  logic                        w_enter;
  logic                        w_do_load;
  logic                        w_do_next;
  logic                        w_do_inc;

  tick_gen #(.DIV(SCAN_DIV)) u_scan_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_tick (w_scan_tick)
  );

  tick_gen #(.DIV(BLINK_DIV)) u_blink_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_tick (w_blink_tick)
  );

  // Button priority mode > next > inc gives at most one action per cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_enter     = 1'b0;
    w_do_load   = 1'b0;
    w_do_next   = 1'b0;
    w_do_inc    = 1'b0;
    case (r_state)
      IDLE: begin
        w_do_load = load;
        if (btn_mode) begin
          w_state_nxt = EDIT;
          w_enter     = 1'b1;
        end
      end
      EDIT: begin
        if (btn_mode)      w_state_nxt = IDLE;
        else if (btn_next) w_do_next   = 1'b1;
        else if (btn_inc)  w_do_inc    = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_sel <= LAST_DIG;
    else if (w_enter)   r_sel <= LAST_DIG;
    else if (w_do_next) r_sel <= (r_sel == '0) ? LAST_DIG : r_sel - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_digits <= '0;
    else if (w_do_load)
      r_digits <= load_bcd;
    else if (w_do_inc)
      r_digits[r_sel*BCD_W +: BCD_W] <= bcd_inc(r_digits[r_sel*BCD_W +: BCD_W]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_scan_idx <= '0;
    else if (w_scan_tick)
      r_scan_idx <= (r_scan_idx == LAST_DIG) ? '0 : r_scan_idx + 1'b1;
  end

  always_comb begin
    w_an_nxt             = ANODE_OFF[NUM_DIGITS-1:0];
    w_an_nxt[r_scan_idx] = 1'b0;
  end

  // Anode, BCD and blink are registered together so the decoder never sees a
  // value from one digit paired with the anode of another.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an_n  <= ~{{(NUM_DIGITS-1){1'b0}}, 1'b1};
      r_bcd   <= '0;
      r_blink <= 1'b0;
    end else begin
      r_an_n  <= w_an_nxt;
      r_bcd   <= r_digits[r_scan_idx*BCD_W +: BCD_W];
      r_blink <= (r_state == EDIT) && (r_scan_idx == r_sel);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_phase <= 1'b0;
    else if (w_blink_tick) r_phase <= ~r_phase;
  end

  assign digits_out  = r_digits;
  assign editing     = (r_state == EDIT);
  assign bcd_out     = r_bcd;
  assign blink_out   = r_blink;
  assign blink_phase = r_phase;
  assign an_n        = r_an_n;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with N=4, SCAN_DIV=4, BLINK_DIV=8.
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] load_bcd;
  logic        btn_mode;
  logic        btn_next;
  logic        btn_inc;
  logic [15:0] digits_out;
  logic        editing;
  logic [3:0]  bcd_out;
  logic        blink_out;
  logic        blink_phase;
  logic [3:0]  an_n;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] exp_q[$];
  logic [3:0] an_tbl[4];
  logic [3:0] bcd_tbl[4];

  seg_scan_ctrl #(
    .NUM_DIGITS (4),
    .SCAN_DIV   (4),
    .BLINK_DIV  (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .load_bcd    (load_bcd),
    .btn_mode    (btn_mode),
    .btn_next    (btn_next),
    .btn_inc     (btn_inc),
    .digits_out  (digits_out),
    .editing     (editing),
    .bcd_out     (bcd_out),
    .blink_out   (blink_out),
    .blink_phase (blink_phase),
    .an_n        (an_n)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks: called at a negedge, return at the next negedge
  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse(input logic m, input logic nx, input logic inc);
    btn_mode = m;
    btn_next = nx;
    btn_inc  = inc;
    @(negedge clk);
    btn_mode = 1'b0;
    btn_next = 1'b0;
    btn_inc  = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] v);
    load     = 1'b1;
    load_bcd = v;
    @(negedge clk);
    load     = 1'b0;
  endtask

  initial begin
    int blinks;
    bit found;
    rst_n    = 1'b0;
    load     = 1'b0;
    load_bcd = '0;
    btn_mode = 1'b0;
    btn_next = 1'b0;
    btn_inc  = 1'b0;
    an_tbl   = '{4'hE, 4'hD, 4'hB, 4'h7};
    bcd_tbl  = '{4'h4, 4'h3, 4'h2, 4'h1};

    step(2);
    check_val("rst_digits", digits_out, 16'h0000);
    check_val("rst_editing", editing, 1'b0);
    check_val("rst_an_n", an_n, 4'hE);
    check_val("rst_bcd", bcd_out, 4'h0);
    check_val("rst_blink", blink_out, 1'b0);
    check_val("rst_phase", blink_phase, 1'b0);

    // 1: load and scan sequence, window aligned to cycles 17..32 after release
    rst_n = 1'b1;
    do_load(16'h1234);
    check_val("t1_load", digits_out, 16'h1234);
    step(15);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(an_tbl[i/4]);
      exp_q.push_back(bcd_tbl[i/4]);
    end
    for (int i = 0; i < 16; i++) begin
      logic [3:0] e_an, e_bcd;
      step(1);
      e_an  = exp_q.pop_front();
      e_bcd = exp_q.pop_front();
      check_val($sformatf("t1_an_%0d", i), an_n, e_an);
      check_val($sformatf("t1_bcd_%0d", i), bcd_out, e_bcd);
    end

    // 2: edit digit 3 up by three; blink only on its slot
    pulse(1, 0, 0);
    check_val("t2_editing", editing, 1'b1);
    pulse(0, 0, 1);
    pulse(0, 0, 1);
    pulse(0, 0, 1);
    check_val("t2_digits", digits_out, 16'h4234);
    blinks = 0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      check_val($sformatf("t2_blink_%0d", i), blink_out, (an_n == 4'b0111));
      if (an_n == 4'b0111) check_val($sformatf("t2_bcd3_%0d", i), bcd_out, 4'h4);
      if (blink_out) blinks++;
    end
    check_val("t2_blink_count", blinks, 4);

    // 3: 9 wraps to 0, next walks and wraps the selection
    pulse(1, 0, 0);
    check_val("t3_idle", editing, 1'b0);
    do_load(16'h9234);
    check_val("t3_load", digits_out, 16'h9234);
    pulse(1, 0, 0);
    pulse(0, 0, 1);
    check_val("t3_wrap9", digits_out, 16'h0234);
    pulse(0, 1, 0);
    pulse(0, 0, 1);
    check_val("t3_sel2", digits_out, 16'h0334);
    pulse(0, 1, 0);
    pulse(0, 1, 0);
    pulse(0, 1, 0);
    pulse(0, 0, 1);
    check_val("t3_sel_wrap", digits_out, 16'h1334);
    pulse(0, 1, 1);
    check_val("t3_next_over_inc", digits_out, 16'h1334);
    pulse(0, 0, 1);
    check_val("t3_after_next", digits_out, 16'h1434);

    // 4: mode wins over next and inc
    pulse(1, 1, 1);
    check_val("t4_editing", editing, 1'b0);
    check_val("t4_digits", digits_out, 16'h1434);
    for (int i = 0; i < 6; i++) begin
      step(1);
      check_val($sformatf("t4_noblink_%0d", i), blink_out, 1'b0);
    end

    // 5: load ignored in EDIT; non-BCD load increments to 0
    pulse(1, 0, 0);
    check_val("t5_edit", editing, 1'b1);
    do_load(16'hFFFF);
    check_val("t5_load_ignored", digits_out, 16'h1434);
    pulse(1, 0, 0);
    do_load(16'hA000);
    check_val("t5_load_A", digits_out, 16'hA000);
    pulse(1, 0, 0);
    pulse(0, 0, 1);
    check_val("t5_nonbcd_inc", digits_out, 16'h0000);
    pulse(0, 0, 1);
    check_val("t5_inc_again", digits_out, 16'h1000);

    // 6: asynchronous reset mid-scan while editing
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      step(1);
      if (an_n != 4'hE) found = 1'b1;
    end
    check_val("t6_midscan_found", found, 1'b1);
    check_val("t6_pre_editing", editing, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_val("t6_digits", digits_out, 16'h0000);
    check_val("t6_editing", editing, 1'b0);
    check_val("t6_an_n", an_n, 4'hE);
    check_val("t6_bcd", bcd_out, 4'h0);
    check_val("t6_blink", blink_out, 1'b0);
    check_val("t6_phase", blink_phase, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(7);
    check_val("t6_ph_c7", blink_phase, 1'b0);
    step(1);
    check_val("t6_ph_c8", blink_phase, 1'b1);
    step(7);
    check_val("t6_ph_c15", blink_phase, 1'b1);
    step(1);
    check_val("t6_ph_c16", blink_phase, 1'b0);
    step(7);
    check_val("t6_ph_c23", blink_phase, 1'b0);
    step(1);
    check_val("t6_ph_c24", blink_phase, 1'b1);

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
